// File: rtl/psum_dequant_accumulator_if.sv
// Handshake bundle between the PE MAC datapath / GLB psum read port and the
// psum dequant-accumulator, plus its output channel toward the requantizer.
interface psum_dequant_accumulator_if;
  logic signed [7:0]  prev_in;
  logic               prev_in_valid;
  logic               prev_in_ready;
  logic signed [15:0] psum_in;
  logic               psum_in_valid;
  logic               psum_in_ready;
  logic signed [20:0] data_out;
  logic               data_out_valid;
  logic               data_out_ready;
  logic               group_done;

  modport master (
    output prev_in, prev_in_valid, psum_in, psum_in_valid, data_out_ready,
    input  prev_in_ready, psum_in_ready, data_out, data_out_valid, group_done
  );

  modport slave (
    input  prev_in, prev_in_valid, psum_in, psum_in_valid, data_out_ready,
    output prev_in_ready, psum_in_ready, data_out, data_out_valid, group_done
  );
endinterface

// File: rtl/psum_dequant_accumulator.sv
// Accumulates up to ACC_MAX signed 16-bit partial sums onto a 21-bit grid,
// optionally seeded with a reloaded 8-bit psum shifted back by DQ_SHIFT so it
// lines up with the bits the requantizer keeps.
module psum_dequant_accumulator #(
  parameter int ACC_MAX  = 6,
  parameter int DQ_SHIFT = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                cfg_acc_num,
  input  logic                      cfg_load_prev,
  psum_dequant_accumulator_if.slave dq
);

  typedef enum logic [1:0] {S_SEED, S_ACC, S_OUT} state_t;

  localparam logic [2:0] ACC_MAX_3 = 3'(ACC_MAX);

  state_t             state, state_nxt;
  logic [2:0]         num_q;
  logic               load_prev_q;
  logic [2:0]         cnt;
  logic signed [20:0] acc;
  logic signed [20:0] seed;
  logic signed [21:0] sum_wide;
  logic               prev_rdy, psum_rdy;
  logic               prev_xfer, psum_xfer, out_xfer, last_psum;

  // 0 means one psum; anything above ACC_MAX is clamped to ACC_MAX
  function automatic logic [2:0] eff_num(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > ACC_MAX_3) return ACC_MAX_3;
    return n;
  endfunction

  // Clamp a 22-bit intermediate sum into the signed 21-bit range
  function automatic logic signed [20:0] sat21(input logic signed [21:0] x);
    if (x > 22'sh0FFFFF) return 21'h0FFFFF;
    if (x < 22'sh300000) return 21'h100000;
    return x[20:0];
  endfunction

  assign seed      = 21'(dq.prev_in) <<< DQ_SHIFT;
  assign sum_wide  = 22'(acc) + 22'(dq.psum_in);
  assign prev_xfer = prev_rdy && dq.prev_in_valid;
  assign psum_xfer = psum_rdy && dq.psum_in_valid;
  assign out_xfer  = (state == S_OUT) && dq.data_out_ready;
  assign last_psum = (cnt == num_q - 3'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_SEED;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_SEED: if (!load_prev_q || prev_xfer) state_nxt = S_ACC;
      S_ACC:  if (psum_xfer && last_psum)    state_nxt = S_OUT;
      S_OUT:  if (out_xfer)                  state_nxt = S_SEED;
      default:                               state_nxt = S_SEED;
    endcase
  end

  // Outputs and readies decoded from state only (never from their own valid)
  always_comb begin
    prev_rdy          = (state == S_SEED) && load_prev_q && !rst;
    psum_rdy          = (state == S_ACC);
    dq.prev_in_ready  = prev_rdy;
    dq.psum_in_ready  = psum_rdy;
    dq.data_out_valid = (state == S_OUT);
    dq.data_out       = acc;
    dq.group_done     = out_xfer;
  end

  // Seed, accumulate, and capture the next group's config as S_SEED is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      num_q       <= eff_num(cfg_acc_num);
      load_prev_q <= cfg_load_prev;
    end else begin
      case (state)
        S_SEED: begin
          if (!load_prev_q) begin
            acc <= '0;
            cnt <= '0;
          end else if (prev_xfer) begin
            acc <= seed;
            cnt <= '0;
          end
        end
        S_ACC: begin
          if (psum_xfer) begin
            acc <= sat21(sum_wide);
            cnt <= last_psum ? 3'd0 : cnt + 3'd1;
          end
        end
        S_OUT: begin
          if (out_xfer) begin
            num_q       <= eff_num(cfg_acc_num);
            load_prev_q <= cfg_load_prev;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_dequant_accumulator.sv
// Bench for psum_dequant_accumulator: directed vector table, backpressure and
// mid-group reset sequences, then randomized groups against a sum model.
module tb_psum_dequant_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cfg_acc_num;
  logic       cfg_load_prev;

  psum_dequant_accumulator_if bus();

  psum_dequant_accumulator #(.ACC_MAX(6), .DQ_SHIFT(12)) dut (
    .clk(clk), .rst(rst), .cfg_acc_num(cfg_acc_num),
    .cfg_load_prev(cfg_load_prev), .dq(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit                 lp;
    int                 num;
    logic signed [7:0]  prev;
    logic [5:0][15:0]   ps;
    longint             exp;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input bit lp, input int num, input int prev,
                              input int p0, input int p1, input int p2,
                              input int p3, input int p4, input int p5,
                              input longint exp);
    vec_t v;
    v.lp = lp; v.num = num; v.prev = 8'(prev); v.exp = exp;
    v.ps[0] = 16'(p0); v.ps[1] = 16'(p1); v.ps[2] = 16'(p2);
    v.ps[3] = 16'(p3); v.ps[4] = 16'(p4); v.ps[5] = 16'(p5);
    return v;
  endfunction

  function automatic int n_eff(input int num);
    if (num < 1) return 1;
    if (num > 6) return 6;
    return num;
  endfunction

  // Reference: seed (prev * 2^12 or 0) plus the first N psums, clamped to 21 bits
  function automatic longint model(input bit lp, input int num, input int prev,
                                   input logic [5:0][15:0] ps);
    longint s;
    s = lp ? longint'(prev) * 4096 : 0;
    for (int i = 0; i < n_eff(num); i++) s += longint'($signed(ps[i]));
    if (s > 1048575)  s = 1048575;
    if (s < -1048576) s = -1048576;
    return s;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s: got no handshake, required one within 100 cycles", name);
    summary();
    $fatal(1, "bench aborted on timeout");
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garble();
    cfg_acc_num   = 3'($urandom);
    cfg_load_prev = 1'($urandom);
  endtask

  // Drive one group's prev_in (if seeded) and psums, then wait for data_out_valid
  task automatic feed_group(input bit lp, input int num, input logic signed [7:0] prev,
                            input logic [5:0][15:0] ps, input bit gaps, output int cycles);
    bit hs;
    int guard;
    cycles = 0;
    if (lp) begin
      hs = 1'b0; guard = 0;
      while (!hs) begin
        bus.prev_in       = prev;
        bus.prev_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        hs = bus.prev_in_valid && bus.prev_in_ready;
        step(); cycles++; guard++;
        if (!hs && guard > 100) timeout("prev_in");
      end
      bus.prev_in_valid = 1'b0;
      bus.prev_in       = 8'($urandom);
    end
    for (int k = 0; k < n_eff(num); k++) begin
      if (gaps && k == 1) garble();
      hs = 1'b0; guard = 0;
      while (!hs) begin
        bus.psum_in       = ps[k];
        bus.psum_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        hs = bus.psum_in_valid && bus.psum_in_ready;
        step(); cycles++; guard++;
        if (!hs && guard > 100) timeout("psum_in");
      end
    end
    bus.psum_in_valid = 1'b0;
    if (gaps) garble();
    guard = 0;
    while (!bus.data_out_valid) begin
      step(); cycles++; guard++;
      if (guard > 100) timeout("data_out_valid");
    end
  endtask

  // Present next group's config, optionally backpressure, then complete the handshake
  task automatic finish_group(input bit nlp, input int nnum, input int hold, input bit push_extra);
    logic signed [20:0] d0;
    cfg_load_prev      = nlp;
    cfg_acc_num        = 3'(nnum);
    d0                 = bus.data_out;
    bus.data_out_ready = 1'b0;
    if (push_extra) begin
      bus.psum_in_valid = 1'b1;
      bus.psum_in       = 16'h1234;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold data_out", bus.data_out, d0);
      check("hold data_out_valid", bus.data_out_valid, 1);
      check("hold psum_in_ready", bus.psum_in_ready, 0);
      check("hold group_done", bus.group_done, 0);
    end
    bus.psum_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
    #1;
    check("group_done pulse", bus.group_done, 1);
    step();
    bus.data_out_ready = 1'b0;
    #1;
    check("data_out_valid after handshake", bus.data_out_valid, 0);
    check("group_done after handshake", bus.group_done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required one within 100000 cycles");
    n_fail++;
    summary();
    $fatal(1, "bench aborted by watchdog");
  end

  initial begin
    int                 cyc;
    bit                 cur_lp, nlp;
    int                 cur_num, nnum;
    logic signed [7:0]  prev;
    logic [5:0][15:0]   ps;
    logic [20:0]        d;
    logic signed [7:0]  rq;

    vecs[0] = mk(0, 3,    0,   100,   -50,     7,     0,     0,     0,      57);
    vecs[1] = mk(1, 2,   -3,  4096,     1,     0,     0,     0,     0,   -8191);
    vecs[2] = mk(1, 6,  127, 16384, 16384, 16384, 16384, 16384, 16384,  618496);
    vecs[3] = mk(0, 0,    0,     5,   999,   999,   999,   999,   999,       5);
    vecs[4] = mk(0, 7,    0,     1,     2,     3,     4,     5,     6,      21);
    vecs[5] = mk(1, 1, -128,-32768,     0,     0,     0,     0,     0, -557056);
    vecs[6] = mk(1, 4,    0,    -1,    -1,    -1,    -1,     0,     0,      -4);
    vecs[7] = mk(0, 5,    0, 32767, 32767, 32767, 32767, 32767,     0,  163835);

    rst                = 1'b1;
    cfg_load_prev      = vecs[0].lp;
    cfg_acc_num        = 3'(vecs[0].num);
    bus.prev_in        = '0;
    bus.prev_in_valid  = 1'b0;
    bus.psum_in        = '0;
    bus.psum_in_valid  = 1'b0;
    bus.data_out_ready = 1'b0;
    repeat (3) step();
    check("reset data_out", bus.data_out, 0);
    check("reset data_out_valid", bus.data_out_valid, 0);
    check("reset group_done", bus.group_done, 0);
    check("reset psum_in_ready", bus.psum_in_ready, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      feed_group(vecs[i].lp, vecs[i].num, vecs[i].prev, vecs[i].ps, 1'b0, cyc);
      check($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].exp);
      check($sformatf("vec%0d latency", i), cyc, n_eff(vecs[i].num) + 1);
      if (i == 1) begin
        d  = bus.data_out;
        rq = d[19:12];
        check("vec1 requantized bits", rq, -2);
      end
      if (i < 7) finish_group(vecs[i+1].lp, vecs[i+1].num, (i == 3) ? 5 : 0, i == 3);
      else       finish_group(1'b0, 4, 0, 1'b0);
    end

    // Reset partway through a 4-psum group, after two psums
    bus.psum_in       = 16'sd1000;
    bus.psum_in_valid = 1'b1;
    step();
    step();
    bus.psum_in = 16'sd2000;
    step();
    check("pre-reset psum_in_ready", bus.psum_in_ready, 1);
    rst               = 1'b1;
    cfg_load_prev     = 1'b1;
    cfg_acc_num       = 3'd2;
    bus.psum_in_valid = 1'b0;
    step();
    check("midreset data_out", bus.data_out, 0);
    check("midreset data_out_valid", bus.data_out_valid, 0);
    check("midreset group_done", bus.group_done, 0);
    check("midreset psum_in_ready", bus.psum_in_ready, 0);
    check("midreset prev_in_ready", bus.prev_in_ready, 0);
    rst = 1'b0;
    #1;
    check("post-reset prev_in_ready", bus.prev_in_ready, 1);
    ps = '0;
    ps[0] = 16'sd300;
    ps[1] = -16'sd1;
    feed_group(1'b1, 2, 8'sd2, ps, 1'b0, cyc);
    check("post-reset data_out", bus.data_out, 8491);
    check("post-reset latency", cyc, 3);
    cur_lp  = 1'($urandom);
    cur_num = $urandom_range(0, 7);
    finish_group(cur_lp, cur_num, 0, 1'b0);

    for (int g = 0; g < 1000; g++) begin
      prev = 8'($urandom);
      ps   = {$urandom, $urandom, $urandom};
      feed_group(cur_lp, cur_num, prev, ps, 1'b1, cyc);
      check($sformatf("rand group %0d data_out", g), bus.data_out,
            model(cur_lp, cur_num, int'(prev), ps));
      nlp  = 1'($urandom);
      nnum = $urandom_range(0, 7);
      finish_group(nlp, nnum, $urandom_range(0, 2), 1'b0);
      cur_lp  = nlp;
      cur_num = nnum;
    end

    summary();
    $finish;
  end
endmodule
